press_multi: RTL and testbench

- Parametrised successor of the single-key edge detector.
- Per channel, in order:
  - synchronises N_KEYS raw key inputs;
  - debounces them;
  - emits one-cycle press, release and auto-repeat pulses plus a debounced level.
- Sits between board KEY pins and game/control logic. Replaces hand-instantiated per-key edge detectors.

---
 rtl/press_pkg.sv | 17 +
 rtl/press_channel.sv | 119 +++++++++++
 rtl/press_multi.sv | 41 ++++
 tb/tb_press_multi.sv | 132 +++++++++++++
 4 files changed

// File: rtl/press_pkg.sv
// Shared types and helpers for the multi-key press detector.
package press_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2
  } rep_state_t;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w > 1) ? w : 1;
  endfunction

endpackage

// File: rtl/press_channel.sv
// One key channel: synchroniser, debounce, auto-repeat FSM and registered pulses.
module press_channel
  import press_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 10,
  parameter int unsigned REPEAT_RATE     = 3,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_key,
  input  logic i_repeat_en,
  output logic o_pressed,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_repeat_pulse
);

  localparam int unsigned DB_W    = cnt_w(DEBOUNCE_CYCLES - 1);
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? (REPEAT_DELAY - 1)
                                                                  : (REPEAT_RATE - 1);
  localparam int unsigned REP_W   = cnt_w(REP_MAX);

  localparam logic             IDLE_LVL   = (ACTIVE_LOW != 0);
  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_W-1:0]        r_db_cnt;
  logic [REP_W-1:0]       r_rep_cnt;
  rep_state_t             r_state;
  logic                   r_pressed;
  logic                   r_press_pulse;
  logic                   r_release_pulse;
  logic                   r_repeat_pulse;

  logic                   w_s;
  logic                   w_differ;
  logic                   w_toggle;
  logic                   w_accept_press;
  logic                   w_accept_release;
  logic [DB_W-1:0]        w_db_cnt_d;
  logic [REP_W-1:0]       w_rep_cnt_d;
  rep_state_t             w_state_d;
  logic                   w_rep_fire;

  // Normalised so that 1 always means "pressed".
  assign w_s              = r_sync[SYNC_STAGES-1] ^ IDLE_LVL;
  assign w_differ         = (w_s != r_pressed);
  assign w_toggle         = w_differ && (r_db_cnt == DB_LAST);
  assign w_accept_press   = w_toggle && !r_pressed;
  assign w_accept_release = w_toggle && r_pressed;
  assign w_db_cnt_d       = (!w_differ || w_toggle) ? '0 : (r_db_cnt + DB_W'(1));

  always_comb begin
    w_state_d   = r_state;
    w_rep_cnt_d = r_rep_cnt;
    w_rep_fire  = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_accept_press) begin
          w_state_d   = HOLD_DELAY;
          w_rep_cnt_d = '0;
        end
      end
      HOLD_DELAY, HOLD_REPEAT: begin
        if (w_accept_release) begin
          w_state_d   = RELEASED;
          w_rep_cnt_d = '0;
        end else if (!i_repeat_en) begin
          // Disabling repeat forces a full REPEAT_DELAY once re-enabled.
          w_state_d   = HOLD_DELAY;
          w_rep_cnt_d = '0;
        end else if (r_rep_cnt == ((r_state == HOLD_DELAY) ? DELAY_LAST : RATE_LAST)) begin
          w_state_d   = HOLD_REPEAT;
          w_rep_cnt_d = '0;
          w_rep_fire  = 1'b1;
        end else begin
          w_rep_cnt_d = r_rep_cnt + REP_W'(1);
        end
      end
      default: begin
        w_state_d   = RELEASED;
        w_rep_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync          <= {SYNC_STAGES{IDLE_LVL}};
      r_db_cnt        <= '0;
      r_rep_cnt       <= '0;
      r_state         <= RELEASED;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_repeat_pulse  <= 1'b0;
    end else begin
      r_sync          <= {r_sync[SYNC_STAGES-2:0], i_key};
      r_db_cnt        <= w_db_cnt_d;
      r_rep_cnt       <= w_rep_cnt_d;
      r_state         <= w_state_d;
      r_pressed       <= r_pressed ^ w_toggle;
      r_press_pulse   <= w_accept_press;
      r_release_pulse <= w_accept_release;
      r_repeat_pulse  <= w_rep_fire;
    end
  end

  assign o_pressed       = r_pressed;
  assign o_press_pulse   = r_press_pulse;
  assign o_release_pulse = r_release_pulse;
  assign o_repeat_pulse  = r_repeat_pulse;

endmodule

// File: rtl/press_multi.sv
// N_KEYS independent debounced key channels with press/release/auto-repeat pulses.
module press_multi
  import press_pkg::*;
#(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 10,
  parameter int unsigned REPEAT_RATE     = 3,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key,
  input  logic              repeat_en,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] repeat_pulse
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    press_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_channel (
      .i_clock         (clock),
      .i_reset_n       (reset_n),
      .i_key           (key[g]),
      .i_repeat_en     (repeat_en),
      .o_pressed       (pressed[g]),
      .o_press_pulse   (press_pulse[g]),
      .o_release_pulse (release_pulse[g]),
      .o_repeat_pulse  (repeat_pulse[g])
    );
  end

endmodule

// File: tb/tb_press_multi.sv
// Directed self-checking bench for press_multi at default parameters (active-low keys).
module tb_press_multi;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] key = 4'b0000;
  logic       repeat_en = 1'b0;
  logic [3:0] pressed;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] repeat_pulse;

  int n_checks = 0;
  int n_err    = 0;

  always #50 clock = ~clock;

  press_multi dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .key           (key),
    .repeat_en     (repeat_en),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp,
                        input int e);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s edge %0d: observed %b expected %b", tag, e, obs, exp);
    end
  endtask

  // Inputs set beforehand are sampled at this edge e; outputs checked just after it.
  task automatic step_chk(input string tc, input int e, input logic [3:0] e_prs,
                          input logic [3:0] e_pp, input logic [3:0] e_rp,
                          input logic [3:0] e_rep);
    tick();
    check4({tc, ".pressed"}, pressed, e_prs, e);
    check4({tc, ".press_pulse"}, press_pulse, e_pp, e);
    check4({tc, ".release_pulse"}, release_pulse, e_rp, e);
    check4({tc, ".repeat_pulse"}, repeat_pulse, e_rep, e);
  endtask

  function automatic logic rep_hit(input int e, input int first, input int stop);
    return (e >= first) && (e < stop) && (((e - first) % 3) == 0);
  endfunction

  initial begin
    // Reset with all keys held down.
    #10;
    check4("rst.pressed", pressed, 4'b0000, -1);
    check4("rst.press_pulse", press_pulse, 4'b0000, -1);
    check4("rst.release_pulse", release_pulse, 4'b0000, -1);
    check4("rst.repeat_pulse", repeat_pulse, 4'b0000, -1);
    repeat (3) tick();
    check4("rst_hold.pressed", pressed, 4'b0000, -1);
    check4("rst_hold.press_pulse", press_pulse, 4'b0000, -1);
    reset_n = 1'b1;

    // Keys held through reset appear as a fresh press at edge 5.
    for (int e = 0; e <= 12; e++)
      step_chk("rst_press", e, (e >= 5) ? 4'b1111 : 4'b0000, (e == 5) ? 4'b1111 : 4'b0000,
               4'b0000, 4'b0000);

    key = 4'b1111;
    for (int e = 0; e <= 10; e++)
      step_chk("rst_release", e, (e < 5) ? 4'b1111 : 4'b0000, 4'b0000,
               (e == 5) ? 4'b1111 : 4'b0000, 4'b0000);

    // Clean press/release on key[0], repeat disabled.
    for (int e = 0; e <= 32; e++) begin
      key = (e < 20) ? 4'b1110 : 4'b1111;
      step_chk("clean", e, (e >= 5 && e < 25) ? 4'b0001 : 4'b0000,
               (e == 5) ? 4'b0001 : 4'b0000, (e == 25) ? 4'b0001 : 4'b0000, 4'b0000);
    end

    // Glitch of 3 cycles on key[1] is discarded.
    for (int e = 0; e <= 12; e++) begin
      key = (e < 3) ? 4'b1101 : 4'b1111;
      step_chk("glitch3", e, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    end

    // Four low cycles are accepted; release follows 4 edges later.
    for (int e = 0; e <= 14; e++) begin
      key = (e < 4) ? 4'b1101 : 4'b1111;
      step_chk("glitch4", e, (e >= 5 && e < 9) ? 4'b0010 : 4'b0000,
               (e == 5) ? 4'b0010 : 4'b0000, (e == 9) ? 4'b0010 : 4'b0000, 4'b0000);
    end

    // Auto-repeat on key[2]: P=5, repeats at 15,18,21,24,27; release at 30 suppresses.
    repeat_en = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      key = (e < 25) ? 4'b1011 : 4'b1111;
      step_chk("repeat", e, (e >= 5 && e < 30) ? 4'b0100 : 4'b0000,
               (e == 5) ? 4'b0100 : 4'b0000, (e == 30) ? 4'b0100 : 4'b0000,
               rep_hit(e, 15, 30) ? 4'b0100 : 4'b0000);
    end

    // repeat_en low for edges P+6..P+8 restarts the delay: first repeat at P+18.
    for (int e = 0; e <= 42; e++) begin
      key       = (e < 30) ? 4'b0111 : 4'b1111;
      repeat_en = !(e >= 11 && e < 14);
      step_chk("rep_en", e, (e >= 5 && e < 35) ? 4'b1000 : 4'b0000,
               (e == 5) ? 4'b1000 : 4'b0000, (e == 35) ? 4'b1000 : 4'b0000,
               rep_hit(e, 23, 35) ? 4'b1000 : 4'b0000);
    end

    // key[0] and key[3] together; key[3] released mid-repeat of key[0].
    repeat_en = 1'b1;
    for (int e = 0; e <= 42; e++) begin
      key = {(e >= 17), 2'b11, (e >= 30)};
      step_chk("indep", e, {(e >= 5 && e < 22), 2'b00, (e >= 5 && e < 35)},
               (e == 5) ? 4'b1001 : 4'b0000, {(e == 22), 2'b00, (e == 35)},
               {rep_hit(e, 15, 22), 2'b00, rep_hit(e, 15, 35)});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
